// File: rtl/rs232_tx_arbiter.sv
// Round-robin scheduler feeding one RS232Txd transmitter from NUM_REQ byte producers.
// Frames are timed locally (the transmitter has no busy flag) and separated by an idle gap.
module rs232_tx_arbiter #(
    parameter int unsigned NUM_REQ          = 4,
    parameter int unsigned SEND_HIGH_CYCLES = 2,
    parameter int unsigned FRAME_CYCLES     = 176,
    parameter int unsigned GAP_CYCLES       = 16,
    localparam int unsigned ID_W            = $clog2(NUM_REQ)
) (
    input  logic                   Clock16x,
    input  logic                   ResetN,
    input  logic                   Enable,
    input  logic [NUM_REQ-1:0]     ReqValid,
    input  logic [8*NUM_REQ-1:0]   ReqData,
    output logic [NUM_REQ-1:0]     ReqReady,
    output logic                   TxSend,
    output logic [7:0]             TxData,
    output logic                   Busy,
    output logic [ID_W-1:0]        ActiveId
);

    localparam int unsigned MAX_A   = (SEND_HIGH_CYCLES > FRAME_CYCLES) ? SEND_HIGH_CYCLES : FRAME_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ID_W-1:0]   r_last;

    logic              w_hi_found;
    logic              w_lo_found;
    logic [ID_W-1:0]   w_hi_idx;
    logic [ID_W-1:0]   w_lo_idx;
    logic [ID_W-1:0]   w_winner;
    logic              w_grant;
    logic [7:0]        w_data;

    // Lowest valid index above the last winner, else lowest valid index overall (wrap).
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (ReqValid[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = ID_W'(i);
                if (ID_W'(i) > r_last) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = ID_W'(i);
                end
            end
        end
    end

    assign w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_grant  = (r_state == ST_IDLE) && Enable && w_lo_found;

    always_comb begin
        ReqReady = '0;
        w_data   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_winner == ID_W'(i)) begin
                ReqReady[i] = w_grant;
                w_data      = ReqData[8*i +: 8];
            end
        end
    end

    // Frame sequencer: LOAD holds Send high, SEND times the serial frame, GAP enforces idle.
    always_ff @(posedge Clock16x or negedge ResetN) begin
        if (!ResetN) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_last   <= ID_W'(NUM_REQ - 1);
            TxSend   <= 1'b0;
            TxData   <= 8'hFF;
            Busy     <= 1'b0;
            ActiveId <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state  <= ST_LOAD;
                        r_cnt    <= CNT_W'(SEND_HIGH_CYCLES - 1);
                        r_last   <= w_winner;
                        TxSend   <= 1'b1;
                        TxData   <= w_data;
                        Busy     <= 1'b1;
                        ActiveId <= w_winner;
                    end
                end
                ST_LOAD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_SEND;
                        r_cnt   <= CNT_W'(FRAME_CYCLES - 1);
                        TxSend  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_GAP;
                        r_cnt   <= CNT_W'(GAP_CYCLES - 1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        Busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    TxSend  <= 1'b0;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Self-checking bench for rs232_tx_arbiter: directed scenarios plus random traffic,
// compared every cycle against a timing model expressed in terms of the last accept cycle.
module tb_rs232_tx_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned S = 2;
    localparam int unsigned F = 176;
    localparam int unsigned G = 16;
    localparam int PERIOD = int'(S + F + G + 1);

    logic           Clock16x;
    logic           ResetN;
    logic           Enable;
    logic [N-1:0]   ReqValid;
    logic [8*N-1:0] ReqData;
    logic [N-1:0]   ReqReady;
    logic           TxSend;
    logic [7:0]     TxData;
    logic           Busy;
    logic [1:0]     ActiveId;

    rs232_tx_arbiter #(
        .NUM_REQ         (N),
        .SEND_HIGH_CYCLES(S),
        .FRAME_CYCLES    (F),
        .GAP_CYCLES      (G)
    ) dut (
        .Clock16x(Clock16x),
        .ResetN  (ResetN),
        .Enable  (Enable),
        .ReqValid(ReqValid),
        .ReqData (ReqData),
        .ReqReady(ReqReady),
        .TxSend  (TxSend),
        .TxData  (TxData),
        .Busy    (Busy),
        .ActiveId(ActiveId)
    );

    initial Clock16x = 1'b0;
    always #5 Clock16x = ~Clock16x;

    int         n_checks;
    int         n_errors;
    int         cyc;
    bit         m_have;
    int         m_t;
    int         m_last;
    logic [7:0] m_txdata;
    int         m_id;
    int         ob_id[$];
    int         ob_t[$];
    int         busy_cnt;
    int         n_falls;
    logic       prev_txsend;
    logic [9:0] last_frame;
    logic [9:0] exp_frame;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Winner: first valid index scanning upward from last+1, wrapping modulo N.
    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= int'(N); k++) begin
            int idx;
            idx = (last + k) % int'(N);
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_have      = 1'b0;
        m_t         = 0;
        m_last      = int'(N) - 1;
        m_txdata    = 8'hFF;
        m_id        = 0;
        prev_txsend = 1'b0;
    endtask

    task automatic clear_obs();
        ob_id.delete();
        ob_t.delete();
        busy_cnt = 0;
        n_falls  = 0;
    endtask

    // One clock: compare mid-cycle, then advance the model on the rising edge.
    task automatic tick();
        int         w;
        bit         idle;
        logic [N-1:0] exp_rdy;
        logic       exp_send;
        logic       exp_busy;
        @(negedge Clock16x);
        #1;
        idle     = !m_have || (cyc > m_t + int'(S + F + G));
        w        = (idle && Enable) ? pick(ReqValid, m_last) : -1;
        exp_rdy  = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        exp_send = m_have && (cyc > m_t) && (cyc <= m_t + int'(S));
        exp_busy = m_have && (cyc > m_t) && (cyc <= m_t + int'(S + F + G));
        check("ReqReady", 32'(ReqReady), 32'(exp_rdy));
        check("TxSend",   32'(TxSend),   32'(exp_send));
        check("Busy",     32'(Busy),     32'(exp_busy));
        check("TxData",   32'(TxData),   32'(m_txdata));
        check("ActiveId", 32'(ActiveId), 32'(m_id));
        for (int i = 0; i < int'(N); i++) begin
            if (ReqReady[i] === 1'b1) begin
                ob_id.push_back(i);
                ob_t.push_back(cyc);
            end
        end
        if (Busy === 1'b1) busy_cnt++;
        if (prev_txsend === 1'b1 && TxSend === 1'b0) begin
            n_falls++;
            last_frame = {1'b1, TxData, 1'b0};
        end
        prev_txsend = TxSend;
        @(posedge Clock16x);
        if (w >= 0) begin
            m_have   = 1'b1;
            m_t      = cyc;
            m_last   = w;
            m_txdata = ReqData[8*w +: 8];
            m_id     = w;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        repeat (2) @(posedge Clock16x);
        #1;
        ResetN = 1'b1;
        model_reset();
    endtask

    task automatic check_order(input string tag, input int exp_ids[5], input int cnt);
        check({tag, "_count"}, 32'(ob_id.size()), 32'(cnt));
        for (int k = 0; k < cnt; k++) begin
            if (k < ob_id.size()) check({tag, "_id"}, 32'(ob_id[k]), 32'(exp_ids[k]));
        end
    endtask

    initial begin
        int exp_bits[10];
        int ord[5];
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        Enable   = 1'b0;
        ReqValid = '0;
        ReqData  = '0;
        ResetN   = 1'b1;
        model_reset();
        clear_obs();
        #1 ResetN = 1'b0;
        #2;
        check("rst_TxSend",   32'(TxSend),   32'h0);
        check("rst_TxData",   32'(TxData),   32'hFF);
        check("rst_Busy",     32'(Busy),     32'h0);
        check("rst_ActiveId", 32'(ActiveId), 32'h0);
        check("rst_ReqReady", 32'(ReqReady), 32'h0);
        repeat (2) @(posedge Clock16x);
        #1 ResetN = 1'b1;

        // Single requester 0 with A5: one frame, busy window, serial image.
        Enable   = 1'b1;
        ReqValid = 4'b0001;
        ReqData  = {24'h0, 8'hA5};
        clear_obs();
        tick();
        ReqValid = '0;
        repeat (219) tick();
        ord = '{0, 0, 0, 0, 0};
        check_order("single", ord, 1);
        check("single_busy_cycles", 32'(busy_cnt), 32'd194);
        check("single_falls", 32'(n_falls), 32'd1);
        exp_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        for (int i = 0; i < 10; i++) exp_frame[i] = exp_bits[i][0];
        check("single_serial", 32'(last_frame), 32'(exp_frame));

        // All four valid: round robin and minimum spacing.
        do_reset();
        ReqValid = 4'b1111;
        ReqData  = 32'h44332211;
        clear_obs();
        repeat (4 * PERIOD + 1) tick();
        ord = '{0, 1, 2, 3, 0};
        check_order("rr", ord, 5);
        for (int k = 1; k < 5; k++) begin
            if (k < ob_t.size()) check("rr_spacing", 32'(ob_t[k] - ob_t[k-1]), 32'(PERIOD));
        end

        // Pointer after requester 2: 3 beats 1.
        do_reset();
        ReqValid = 4'b0100;
        ReqData  = 32'hDEADBEEF;
        clear_obs();
        tick();
        ReqValid = 4'b1010;
        repeat (2 * PERIOD) tick();
        ord = '{2, 3, 1, 0, 0};
        check_order("ptr", ord, 3);

        // Enable low blocks grants; dropping it mid-frame lets the frame finish.
        do_reset();
        Enable   = 1'b0;
        ReqValid = 4'b1111;
        clear_obs();
        repeat (500) tick();
        check("dis_grants", 32'(ob_id.size()), 32'd0);
        check("dis_busy", 32'(busy_cnt), 32'd0);
        Enable = 1'b1;
        clear_obs();
        tick();
        repeat (100) tick();
        Enable = 1'b0;
        repeat (300) tick();
        check("drop_en_grants", 32'(ob_id.size()), 32'd1);
        check("drop_en_busy", 32'(busy_cnt), 32'd194);

        // Asynchronous reset mid-SEND.
        do_reset();
        Enable   = 1'b1;
        ReqValid = 4'b0010;
        ReqData  = 32'h00005A00;
        tick();
        ReqValid = '0;
        repeat (80) tick();
        ReqValid = 4'b1111;
        #2 ResetN = 1'b0;
        #1;
        check("arst_TxSend",   32'(TxSend),   32'h0);
        check("arst_TxData",   32'(TxData),   32'hFF);
        check("arst_Busy",     32'(Busy),     32'h0);
        check("arst_ActiveId", 32'(ActiveId), 32'h0);
        repeat (2) @(posedge Clock16x);
        #1 ResetN = 1'b1;
        model_reset();
        clear_obs();
        tick();
        ord = '{0, 0, 0, 0, 0};
        check_order("arst_first", ord, 1);

        // Requesters 1 and 3 together straight after reset: 1 wins.
        ReqValid = 4'b1010;
        do_reset();
        clear_obs();
        tick();
        ord = '{1, 0, 0, 0, 0};
        check_order("sim_rise", ord, 1);

        // Random traffic against the model.
        do_reset();
        Enable = 1'b1;
        repeat (8000) begin
            if ($urandom_range(0, 39) == 0) ReqValid = N'($urandom);
            if ($urandom_range(0, 2) == 0)  ReqData  = $urandom;
            if ($urandom_range(0, 299) == 0) Enable  = ~Enable;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
